// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline handshake controller: flush FSM
// encoding, default exception vector and stage indices.
package pipe_pkg;

    // Flush sequencer states
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // PC loaded on a non-eret exception
    localparam logic [31:0] EXC_VEC_DEFAULT = 32'hBFC0_0380;

    // Downstream stage indices (IF is the source and has no slot)
    localparam int STG_ID  = 0;
    localparam int STG_EXE = 1;
    localparam int STG_MEM = 2;
    localparam int STG_WB  = 3;
    localparam int NUM_STG = 4;

endpackage

// File: rtl/pipe_valid_slot.sv
// One pipeline stage's valid bit with its completion (over) and
// acceptance (allow_in) logic.
// Handshake: a stage hands its instruction on when over_o is high and the
// successor's allow_in is high in the same cycle; allow_in_o means this
// slot either is empty or is emptying this cycle.
module pipe_valid_slot (
    input  logic clk,
    input  logic reset,
    input  logic cancel_i,
    input  logic pred_over_i,
    input  logic ready_i,
    input  logic kill_i,
    input  logic next_allow_in_i,
    output logic valid_o,
    output logic over_o,
    output logic allow_in_o
);

    logic valid_q;
    logic valid_d;

    // Completion and acceptance derived from the current valid bit
    always_comb begin
        over_o     = valid_q & ready_i & ~kill_i;
        allow_in_o = ~valid_q | (over_o & next_allow_in_i);
    end

    // Next valid: flush clears, an open slot takes the predecessor's output
    always_comb begin
        valid_d = valid_q;
        if (cancel_i) begin
            valid_d = 1'b0;
        end else if (allow_in_o) begin
            valid_d = pred_over_i;
        end
    end

    // Valid bit register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign valid_o = valid_q;

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Central handshake controller for the IF/ID/EXE/MEM/WB pipeline: valid
// tracking per stage, exception flush sequencing and a stall counter.
module pipe_stage_ctrl
    import pipe_pkg::*;
#(
    parameter int          CNT_W   = 32,
    parameter logic [31:0] EXC_VEC = EXC_VEC_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IF_over,
    input  logic             ID_ready,
    input  logic             EXE_ready,
    input  logic             MEM_ready,
    input  logic             MEM_exc,
    input  logic [31:0]      exc_pc,
    input  logic             exc_is_eret,
    input  logic             fetch_idle,
    output logic             ID_allow_in,
    output logic             EXE_allow_in,
    output logic             MEM_allow_in,
    output logic             WB_allow_in,
    output logic             ID_over,
    output logic             EXE_over,
    output logic             MEM_over,
    output logic             WB_over,
    output logic             cancel,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             fetch_hold,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic v_id, v_exe, v_mem, v_wb;
    logic if_over_eff;
    logic exc_take;
    logic unused_v;

    // Fetch output is discarded while a flush is in progress
    assign if_over_eff = IF_over & (state_q == ST_RUN);
    assign exc_take    = (state_q == ST_RUN) & v_mem & MEM_exc;

    pipe_valid_slot u_id (
        .clk(clk), .reset(reset), .cancel_i(cancel),
        .pred_over_i(if_over_eff), .ready_i(ID_ready), .kill_i(1'b0),
        .next_allow_in_i(EXE_allow_in),
        .valid_o(v_id), .over_o(ID_over), .allow_in_o(ID_allow_in)
    );

    pipe_valid_slot u_exe (
        .clk(clk), .reset(reset), .cancel_i(cancel),
        .pred_over_i(ID_over), .ready_i(EXE_ready), .kill_i(1'b0),
        .next_allow_in_i(MEM_allow_in),
        .valid_o(v_exe), .over_o(EXE_over), .allow_in_o(EXE_allow_in)
    );

    // A faulting MEM instruction never completes, so it never reaches WB
    pipe_valid_slot u_mem (
        .clk(clk), .reset(reset), .cancel_i(cancel),
        .pred_over_i(EXE_over), .ready_i(MEM_ready), .kill_i(MEM_exc),
        .next_allow_in_i(WB_allow_in),
        .valid_o(v_mem), .over_o(MEM_over), .allow_in_o(MEM_allow_in)
    );

    // WB always completes; its retire is visible before cancel clears it
    pipe_valid_slot u_wb (
        .clk(clk), .reset(reset), .cancel_i(cancel),
        .pred_over_i(MEM_over), .ready_i(1'b1), .kill_i(1'b0),
        .next_allow_in_i(1'b1),
        .valid_o(v_wb), .over_o(WB_over), .allow_in_o(WB_allow_in)
    );

    assign unused_v = &{1'b0, v_exe, v_wb};

    // Flush sequencer: RUN -> FLUSH (one cycle) -> DRAIN until fetch idle
    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        case (state_q)
            ST_RUN: begin
                if (exc_take) begin
                    state_d       = ST_FLUSH;
                    redirect_pc_d = exc_is_eret ? exc_pc : EXC_VEC;
                end
            end
            ST_FLUSH: state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (fetch_idle) begin
                    state_d = ST_RUN;
                end
            end
            default:  state_d = ST_RUN;
        endcase
    end

    // Saturating count of cycles where ID holds an instruction it cannot finish
    always_comb begin
        stall_d = stall_q;
        if ((state_q == ST_RUN) && v_id && !ID_over && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_ONE;
        end
    end

    // State, redirect target and stall counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RUN;
            redirect_pc_q <= 32'h0;
            stall_q       <= '0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
            stall_q       <= stall_d;
        end
    end

    assign cancel         = (state_q == ST_FLUSH);
    assign redirect_valid = (state_q == ST_FLUSH);
    assign fetch_hold     = (state_q == ST_FLUSH) | (state_q == ST_DRAIN);
    assign redirect_pc    = redirect_pc_q;
    assign stall_cycles   = stall_q;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Directed-vector bench for pipe_stage_ctrl with an expected-value queue.
module tb_pipe_stage_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        IF_over, ID_ready, EXE_ready, MEM_ready, MEM_exc;
    logic [31:0] exc_pc;
    logic        exc_is_eret, fetch_idle;

    logic        ID_allow_in, EXE_allow_in, MEM_allow_in, WB_allow_in;
    logic        ID_over, EXE_over, MEM_over, WB_over;
    logic        cancel, redirect_valid, fetch_hold;
    logic [31:0] redirect_pc;
    logic [31:0] stall_cycles;

    logic        d4_ID_allow_in, d4_EXE_allow_in, d4_MEM_allow_in, d4_WB_allow_in;
    logic        d4_ID_over, d4_EXE_over, d4_MEM_over, d4_WB_over;
    logic        d4_cancel, d4_redirect_valid, d4_fetch_hold;
    logic [31:0] d4_redirect_pc;
    logic [3:0]  d4_stall_cycles;

    // clock / reset
    always #5 clk = ~clk;

    pipe_stage_ctrl dut (
        .clk(clk), .reset(reset), .IF_over(IF_over), .ID_ready(ID_ready),
        .EXE_ready(EXE_ready), .MEM_ready(MEM_ready), .MEM_exc(MEM_exc),
        .exc_pc(exc_pc), .exc_is_eret(exc_is_eret), .fetch_idle(fetch_idle),
        .ID_allow_in(ID_allow_in), .EXE_allow_in(EXE_allow_in),
        .MEM_allow_in(MEM_allow_in), .WB_allow_in(WB_allow_in),
        .ID_over(ID_over), .EXE_over(EXE_over), .MEM_over(MEM_over), .WB_over(WB_over),
        .cancel(cancel), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_hold(fetch_hold), .stall_cycles(stall_cycles)
    );

    pipe_stage_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .IF_over(IF_over), .ID_ready(ID_ready),
        .EXE_ready(EXE_ready), .MEM_ready(MEM_ready), .MEM_exc(MEM_exc),
        .exc_pc(exc_pc), .exc_is_eret(exc_is_eret), .fetch_idle(fetch_idle),
        .ID_allow_in(d4_ID_allow_in), .EXE_allow_in(d4_EXE_allow_in),
        .MEM_allow_in(d4_MEM_allow_in), .WB_allow_in(d4_WB_allow_in),
        .ID_over(d4_ID_over), .EXE_over(d4_EXE_over), .MEM_over(d4_MEM_over), .WB_over(d4_WB_over),
        .cancel(d4_cancel), .redirect_valid(d4_redirect_valid), .redirect_pc(d4_redirect_pc),
        .fetch_hold(d4_fetch_hold), .stall_cycles(d4_stall_cycles)
    );

    typedef struct packed {
        logic [3:0]  allow;   // {ID, EXE, MEM, WB}
        logic [3:0]  over;    // {ID, EXE, MEM, WB}
        logic [2:0]  ctl;     // {cancel, redirect_valid, fetch_hold}
        logic [31:0] rpc;
        logic [31:0] stall;
        logic [3:0]  stall4;
    } exp_t;

    exp_t        exp_q[$];
    string       name_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] rpc_exp;

    // driver tasks
    task automatic expect_now(input string nm, input logic [3:0] alw, input logic [3:0] ovr,
                              input logic [2:0] ctl, input int stall);
        exp_t e;
        e.allow  = alw;
        e.over   = ovr;
        e.ctl    = ctl;
        e.rpc    = rpc_exp;
        e.stall  = 32'(stall);
        e.stall4 = (stall > 15) ? 4'hF : 4'(stall);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // in7 = {IF_over, ID_ready, EXE_ready, MEM_ready, MEM_exc, exc_is_eret, fetch_idle}
    task automatic drive(input logic [6:0] in7);
        {IF_over, ID_ready, EXE_ready, MEM_ready, MEM_exc, exc_is_eret, fetch_idle} = in7;
    endtask

    task automatic step(input string nm, input logic [6:0] in7, input logic [3:0] alw,
                        input logic [3:0] ovr, input logic [2:0] ctl, input int stall);
        drive(in7);
        expect_now(nm, alw, ovr, ctl, stall);
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor: samples mid-cycle, away from the active edge
    always @(negedge clk) begin
        exp_t  e;
        exp_t  a;
        string nm;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            nm = name_q.pop_front();
            a.allow  = {ID_allow_in, EXE_allow_in, MEM_allow_in, WB_allow_in};
            a.over   = {ID_over, EXE_over, MEM_over, WB_over};
            a.ctl    = {cancel, redirect_valid, fetch_hold};
            a.rpc    = redirect_pc;
            a.stall  = stall_cycles;
            a.stall4 = d4_stall_cycles;
            n_vec++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got allow=%b over=%b ctl=%b pc=%h stall=%0d stall4=%0d, want allow=%b over=%b ctl=%b pc=%h stall=%0d stall4=%0d",
                         nm, a.allow, a.over, a.ctl, a.rpc, a.stall, a.stall4,
                         e.allow, e.over, e.ctl, e.rpc, e.stall, e.stall4);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        exc_pc  = 32'h8000_1234;
        rpc_exp = 32'h0;
        drive(7'b0000000);
        @(posedge clk);
        #1;
        step("reset_state", 7'b1111001, 4'b1111, 4'b0000, 3'b000, 0);
        reset = 1'b0;

        // fill with zero bubbles
        step("fill0", 7'b1111001, 4'b1111, 4'b0000, 3'b000, 0);
        step("fill1", 7'b1111001, 4'b1111, 4'b1000, 3'b000, 0);
        step("fill2", 7'b1111001, 4'b1111, 4'b1100, 3'b000, 0);
        step("fill3", 7'b1111001, 4'b1111, 4'b1110, 3'b000, 0);
        step("fill4", 7'b1111001, 4'b1111, 4'b1111, 3'b000, 0);
        step("fill5", 7'b1111001, 4'b1111, 4'b1111, 3'b000, 0);

        // ID load-use stall for 3 cycles
        step("id_stall1", 7'b1011001, 4'b0111, 4'b0111, 3'b000, 0);
        step("id_stall2", 7'b1011001, 4'b0111, 4'b0011, 3'b000, 1);
        step("id_stall3", 7'b1011001, 4'b0111, 4'b0001, 3'b000, 2);
        step("id_rel1",   7'b1111001, 4'b1111, 4'b1000, 3'b000, 3);
        step("id_rel2",   7'b1111001, 4'b1111, 4'b1100, 3'b000, 3);
        step("id_rel3",   7'b1111001, 4'b1111, 4'b1110, 3'b000, 3);
        step("id_rel4",   7'b1111001, 4'b1111, 4'b1111, 3'b000, 3);

        // EXE busy for 5 cycles
        step("exe_stall1", 7'b1101001, 4'b0011, 4'b1011, 3'b000, 3);
        step("exe_stall2", 7'b1101001, 4'b0011, 4'b1001, 3'b000, 3);
        step("exe_stall3", 7'b1101001, 4'b0011, 4'b1000, 3'b000, 3);
        step("exe_stall4", 7'b1101001, 4'b0011, 4'b1000, 3'b000, 3);
        step("exe_stall5", 7'b1101001, 4'b0011, 4'b1000, 3'b000, 3);
        step("exe_rel1",   7'b1111001, 4'b1111, 4'b1100, 3'b000, 3);
        step("exe_rel2",   7'b1111001, 4'b1111, 4'b1110, 3'b000, 3);
        step("exe_rel3",   7'b1111001, 4'b1111, 4'b1111, 3'b000, 3);

        // exception with busy fetch; WB still retires in the exception cycle
        step("exc_raise", 7'b1111100, 4'b0001, 4'b1101, 3'b000, 3);
        rpc_exp = 32'hBFC0_0380;
        step("exc_flush", 7'b1111000, 4'b1111, 4'b1110, 3'b111, 3);
        step("exc_drain1_exc_ignored", 7'b1111100, 4'b1111, 4'b0000, 3'b001, 3);
        step("exc_drain2", 7'b1111001, 4'b1111, 4'b0000, 3'b001, 3);
        step("exc_run",    7'b1111001, 4'b1111, 4'b0000, 3'b000, 3);
        step("exc_refill1", 7'b1111001, 4'b1111, 4'b1000, 3'b000, 3);
        step("exc_refill2", 7'b1111001, 4'b1111, 4'b1100, 3'b000, 3);
        step("exc_refill3", 7'b1111001, 4'b1111, 4'b1110, 3'b000, 3);

        // eret redirect, fetch already idle
        step("eret_raise", 7'b1111111, 4'b0001, 4'b1101, 3'b000, 3);
        rpc_exp = 32'h8000_1234;
        step("eret_flush", 7'b1111001, 4'b1111, 4'b1110, 3'b111, 3);
        step("eret_drain", 7'b1111001, 4'b1111, 4'b0000, 3'b001, 3);
        step("eret_run",   7'b1111001, 4'b1111, 4'b0000, 3'b000, 3);
        step("eret_refill1", 7'b1111001, 4'b1111, 4'b1000, 3'b000, 3);
        step("eret_refill2", 7'b1111001, 4'b1111, 4'b1100, 3'b000, 3);

        // exception, then asynchronous reset while draining
        step("drn_raise", 7'b1111100, 4'b0001, 4'b1100, 3'b000, 3);
        rpc_exp = 32'hBFC0_0380;
        step("drn_flush", 7'b1111000, 4'b1111, 4'b1110, 3'b111, 3);
        step("drn_wait",  7'b1111000, 4'b1111, 4'b0000, 3'b001, 3);
        drive(7'b1111000);
        #1;
        reset   = 1'b1;
        rpc_exp = 32'h0;
        expect_now("async_reset_in_drain", 4'b1111, 4'b0000, 3'b000, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step("post_reset", 7'b1111001, 4'b1111, 4'b0000, 3'b000, 0);

        // 20 stall cycles: wide counter counts, 4-bit counter saturates
        for (int k = 0; k < 20; k++) begin
            step("stall_sat", 7'b1011001, 4'b0111, 4'b0000, 3'b000, k);
        end
        step("stall_final", 7'b1111001, 4'b1111, 4'b1000, 3'b000, 20);

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_ctrl.md
Name: pipe_stage_ctrl

Overview:
- Central handshake controller for the 5-stage pipeline (IF, ID, EXE, MEM, WB).
- Tracks one valid bit per downstream stage and derives every stage's `*_over` and `*_allow_in` signals.
- Sequences the exception flush: `cancel` pulse, PC redirect, then wait for fetch drain.
- Drives the enables of the ID/EXE, EXE/MEM and MEM/WB pipeline registers; keeps a saturating stall counter for debug.

Parameters:
- CNT_W, 32, width of stall_cycles counter (saturates at all-ones)
- EXC_VEC, 32'hBFC00380, PC driven on redirect_pc during flush

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- IF_over  input  1  fetch stage holds a completed instruction
- ID_ready  input  1  ID may complete (0 = load-use hazard)
- EXE_ready  input  1  EXE result available (0 = mul/div busy)
- MEM_ready  input  1  data access acknowledged
- MEM_exc  input  1  instruction in MEM raises exception/eret (qualified by MEM valid internally)
- exc_pc  input  32  target PC for eret; ignored when exc_is_eret=0
- exc_is_eret  input  1  MEM_exc is an eret
- fetch_idle  input  1  no outstanding instruction fetch
- ID_allow_in, EXE_allow_in, MEM_allow_in, WB_allow_in  output  1 each  stage may accept new data
- ID_over, EXE_over, MEM_over, WB_over  output  1 each  stage valid and complete
- cancel  output  1  flush all pipeline registers
- redirect_valid  output  1  load redirect_pc into fetch PC
- redirect_pc  output  32  redirect target
- fetch_hold  output  1  fetch must not issue new requests
- stall_cycles  output  CNT_W  saturating count of cycles with v_ID=1 & ID_over=0

Behaviour:
- Reset (asynchronous, active-high): v_ID=v_EXE=v_MEM=v_WB=0, state=RUN, stall_cycles=0, redirect_pc=0. All outputs take combinational values from these (cancel=0, redirect_valid=0, fetch_hold=0, all allow_in=1, all over=0).
- Combinational rules:
  - ID_over = v_ID & ID_ready
  - EXE_over = v_EXE & EXE_ready
  - MEM_over = v_MEM & MEM_ready & ~MEM_exc
  - WB_over = v_WB
  - WB_allow_in = 1
  - X_allow_in = ~v_X | (X_over & next_allow_in), for X in ID, EXE, MEM
- Sequential update per stage X with predecessor P (P=IF uses IF_over):
  - cancel=1: v_X <= 0
  - else if X_allow_in: v_X <= P_over
  - else v_X holds
- Zero-bubble throughput: all stages full and ready → each register advances every cycle.
- MEM_exc with v_MEM=1 suppresses MEM_over, so the faulting instruction never reaches WB.
- FSM states:
  - RUN:
    - cancel=0
    - if v_MEM & MEM_exc → FLUSH, latching redirect_pc = exc_is_eret ? exc_pc : EXC_VEC
  - FLUSH (exactly 1 cycle):
    - cancel=1, redirect_valid=1, fetch_hold=1
    - → DRAIN
  - DRAIN:
    - fetch_hold=1, cancel=0
    - stays until fetch_idle=1, then → RUN next cycle
    - IF_over is masked to 0 for valid updates while in FLUSH/DRAIN (the stale fetch is discarded)
- Simultaneous MEM_exc and full stalls: the exception wins; the flush clears all valid bits regardless of ready inputs.
- WB is never flushed by cancel in the same cycle its instruction commits: WB_over is evaluated before the clear, so its retire is honoured.
- MEM_exc while not in RUN: ignored (pipeline already empty).
- fetch_idle already 1 on entering DRAIN: DRAIN lasts exactly 1 cycle.
- stall_cycles:
  - increments when state=RUN & v_ID & ~ID_over
  - saturates at 2^CNT_W-1
  - not cleared by cancel
- Reset mid-flush: returns immediately to RUN with everything cleared.
- Latency: MEM_exc asserted in cycle t → cancel/redirect_valid in t+1 → earliest RUN in t+3.

Decomposition:
- Shared package pipe_pkg:
  - FSM state encoding (RUN=2'd0, FLUSH=2'd1, DRAIN=2'd2)
  - EXC_VEC default constant
  - stage index constants
- One sub-module is natural: pipe_valid_slot, holding one valid bit plus its over/allow_in logic, instantiated for ID, EXE, MEM and WB.
- FSM and counter live in the top level.

Test Plan:
- Reset, then IF_over=1 and all ready=1 for 6 cycles → v_WB=1 at cycle 4; WB_over=1 every cycle thereafter; stall_cycles=0.
- Full pipe, ID_ready=0 for 3 cycles → ID_allow_in=0 and IF must hold; EXE gets bubbles (v_EXE=0 after its occupant drains); stall_cycles=3; flow resumes with no instruction lost or duplicated.
- EXE_ready=0 for 5 cycles with full pipe → EXE_allow_in=0 and ID_allow_in=0; MEM/WB drain to empty; on release, order is preserved.
- MEM_exc=1 (exc_is_eret=0) with all stages valid and fetch_idle=0 for 2 cycles:
  - next cycle: cancel=1, redirect_pc=32'hBFC00380, then all v=0
  - fetch_hold stays 1 until fetch_idle=1; return to RUN 1 cycle later
  - WB instruction from the exception cycle still retires
- Eret: MEM_exc=1, exc_is_eret=1, exc_pc=32'h8000_1234 → redirect_pc=32'h8000_1234 with redirect_valid=1 for exactly 1 cycle.
- Assert reset during DRAIN → all valid bits 0, cancel=0, fetch_hold=0 immediately (asynchronous); CNT_W=4 run with 20 stall cycles → stall_cycles=4'hF.
